instr_sequencer: RTL and testbench

- Multi-cycle control FSM for the binary core.
- Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file and memories.
- Consumes `opcode` and `is_alu_operation` from the decoder, and drives enables, memory handshakes and PC control.
- Sits between the instruction/data memory interfaces and the datapath register file.

---
 rtl/instr_sequencer.sv | 137 +++++++++++++
 tb/tb_instr_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback control FSM
// Optional perf counters (cycle_count, retired_count) under `SEQ_PERF_COUNT_EN.
module instr_sequencer #(
  parameter int OPCODE_SIZE = 4
`ifdef SEQ_PERF_COUNT_EN
  , parameter int PERF_CNT_WIDTH = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   is_alu_operation,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic                   zero_flag,
  output logic                   imem_req,
  output logic                   ir_load,
  output logic                   alu_enable,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic                   reg_write,
  output logic                   wb_sel_mem,
  output logic                   pc_inc,
  output logic                   pc_load,
  output logic                   halted,
  output logic                   illegal_op
`ifdef SEQ_PERF_COUNT_EN
  , output logic [PERF_CNT_WIDTH-1:0] cycle_count
  , output logic [PERF_CNT_WIDTH-1:0] retired_count
`endif
);

  localparam logic [OPCODE_SIZE-1:0] OP_LOAD  = OPCODE_SIZE'(8);
  localparam logic [OPCODE_SIZE-1:0] OP_STORE = OPCODE_SIZE'(9);
  localparam logic [OPCODE_SIZE-1:0] OP_JUMP  = OPCODE_SIZE'(10);
  localparam logic [OPCODE_SIZE-1:0] OP_JUMPZ = OPCODE_SIZE'(11);
  localparam logic [OPCODE_SIZE-1:0] OP_HALT  = OPCODE_SIZE'(12);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_BRANCH, S_HALTED
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: if (imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_alu_operation)                           state_d = S_EXECUTE;
        else if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM;
        else if (opcode == OP_JUMP || opcode == OP_JUMPZ) state_d = S_BRANCH;
        else begin
          state_d   = S_HALTED;
          illegal_d = (opcode != OP_HALT);
        end
      end
      S_EXECUTE: state_d = S_WRITEBACK;
      S_MEM: if (dmem_ready) state_d = (opcode == OP_STORE) ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_HALTED:    state_d = S_HALTED;
      default:     state_d = S_FETCH;
    endcase
  end

  // Everything is forced low while reset is held, even before the first edge.
  always_comb begin
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    alu_enable = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    wb_sel_mem = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      illegal_op = illegal_q;
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ready;
          pc_inc   = imem_ready;
        end
        S_EXECUTE: alu_enable = 1'b1;
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OP_STORE);
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          wb_sel_mem = (opcode == OP_LOAD);
        end
        S_BRANCH: pc_load = (opcode == OP_JUMP) || (opcode == OP_JUMPZ && zero_flag);
        S_HALTED: halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_COUNT_EN
  logic [PERF_CNT_WIDTH-1:0] cycle_count_q, retired_count_q;
  logic                      retire;

  assign retire = (state_q == S_WRITEBACK) || (state_q == S_BRANCH) ||
                  (state_q == S_MEM && dmem_ready && opcode == OP_STORE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count_q   <= '0;
      retired_count_q <= '0;
    end else begin
      if (state_q != S_HALTED) cycle_count_q <= cycle_count_q + 1'b1;
      if (retire)              retired_count_q <= retired_count_q + 1'b1;
    end
  end

  assign cycle_count   = cycle_count_q;
  assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized instruction streams checked against a per-instruction phase model
module tb_instr_sequencer;
  localparam logic [3:0] OP_ADD = 4'd0, OP_LOAD = 4'd8, OP_STORE = 4'd9,
                         OP_JUMP = 4'd10, OP_JUMPZ = 4'd11, OP_HALT = 4'd12;

  localparam logic [10:0] M_IMREQ = 11'h400, M_IRLD = 11'h200, M_ALU = 11'h100,
                          M_DREQ = 11'h080, M_DWE = 11'h040, M_RW = 11'h020,
                          M_WBM = 11'h010, M_PCI = 11'h008, M_PCL = 11'h004,
                          M_HLT = 11'h002, M_ILL = 11'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, is_alu_operation, imem_ready, dmem_ready, zero_flag;
  logic [3:0] opcode;
  logic       imem_req, ir_load, alu_enable, dmem_req, dmem_we, reg_write;
  logic       wb_sel_mem, pc_inc, pc_load, halted, illegal_op;
`ifdef SEQ_PERF_COUNT_EN
  logic [15:0] cycle_count, retired_count;
`endif

  instr_sequencer #(.OPCODE_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .is_alu_operation(is_alu_operation),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero_flag(zero_flag),
    .imem_req(imem_req), .ir_load(ir_load), .alu_enable(alu_enable),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .wb_sel_mem(wb_sel_mem), .pc_inc(pc_inc), .pc_load(pc_load),
    .halted(halted), .illegal_op(illegal_op)
`ifdef SEQ_PERF_COUNT_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );

  logic [10:0] obs;
  assign obs = {imem_req, ir_load, alu_enable, dmem_req, dmem_we, reg_write,
                wb_sel_mem, pc_inc, pc_load, halted, illegal_op};

  int checks = 0, failures = 0;
  int exp_cyc = 0, exp_ret = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 = reset cycle, 1 = running cycle, 2 = halted cycle
  task automatic step(input string tag, input logic [10:0] exp, input int kind);
    #1;
    check_eq(tag, {21'd0, obs}, {21'd0, exp});
`ifdef SEQ_PERF_COUNT_EN
    if (kind != 0) begin
      check_eq({tag, "_cyc"}, {16'd0, cycle_count}, exp_cyc & 32'hFFFF);
      check_eq({tag, "_ret"}, {16'd0, retired_count}, exp_ret & 32'hFFFF);
    end
`endif
    @(posedge clk);
    if (kind == 1) exp_cyc++;
    @(negedge clk);
  endtask

  task automatic noise();
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      noise();
      step("reset", 11'h000, 0);
    end
    rst_n   = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic zf, input int iw,
                           input int dw, input bit abort);
    for (int i = 0; i <= iw; i++) begin
      imem_ready = (i == iw);
      dmem_ready = 1'($urandom);
      step("fetch", M_IMREQ | ((i == iw) ? (M_IRLD | M_PCI) : 11'h000), 1);
    end
    noise();
    opcode = op;
    is_alu_operation = (op < 4'd8);
    zero_flag = zf;
    step("decode", 11'h000, 1);
    if (op < 4'd8) begin
      noise(); step("execute", M_ALU, 1);
      noise(); step("wb_alu", M_RW, 1);
      exp_ret++;
    end else if (op == OP_LOAD || op == OP_STORE) begin
      for (int j = 0; j <= dw; j++) begin
        if (abort && j == 2) begin
          do_reset(1);
          return;
        end
        dmem_ready = (j == dw);
        imem_ready = 1'($urandom);
        step("mem", M_DREQ | ((op == OP_STORE) ? M_DWE : 11'h000), 1);
      end
      if (op == OP_LOAD) begin
        noise(); step("wb_load", M_RW | M_WBM, 1);
      end
      exp_ret++;
    end else if (op == OP_JUMP || op == OP_JUMPZ) begin
      noise();
      step("branch", (op == OP_JUMP || zf) ? M_PCL : 11'h000, 1);
      exp_ret++;
    end else begin
      for (int k = 0; k < 20; k++) begin
        noise();
        zero_flag = 1'($urandom);
        step("halted", M_HLT | ((op != OP_HALT) ? M_ILL : 11'h000), 2);
      end
      do_reset(1);
    end
  endtask

  initial begin
    logic [3:0] op;
    rst_n = 1'b0; opcode = '0; is_alu_operation = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; zero_flag = 1'b0;
    @(negedge clk);
    do_reset(2);

    run_instr(OP_ADD,   1'b0, 0, 0, 1'b0);
    run_instr(OP_LOAD,  1'b0, 0, 3, 1'b0);
    run_instr(OP_STORE, 1'b0, 2, 1, 1'b0);
    run_instr(OP_JUMPZ, 1'b0, 0, 0, 1'b0);
    run_instr(OP_JUMPZ, 1'b1, 0, 0, 1'b0);
    run_instr(OP_JUMP,  1'b0, 1, 0, 1'b0);
    run_instr(4'd14,    1'b0, 0, 0, 1'b0);
    run_instr(OP_LOAD,  1'b0, 0, 5, 1'b1);
    run_instr(OP_ADD,   1'b1, 0, 0, 1'b0);
    run_instr(OP_HALT,  1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op >= OP_HALT && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 11));
      run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
